// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing constants and counter type shared with downstream pixel stages
package vga_pkg;

    localparam int CNT_W       = 10;
    localparam int FRAME_CNT_W = 5;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t H_VISIBLE = cnt_t'(640);
    localparam cnt_t H_FRONT   = cnt_t'(16);
    localparam cnt_t H_SYNC    = cnt_t'(96);
    localparam cnt_t H_BACK    = cnt_t'(48);
    localparam cnt_t H_TOTAL   = cnt_t'(800);

    localparam cnt_t V_VISIBLE = cnt_t'(480);
    localparam cnt_t V_FRONT   = cnt_t'(10);
    localparam cnt_t V_SYNC    = cnt_t'(2);
    localparam cnt_t V_BACK    = cnt_t'(33);
    localparam cnt_t V_TOTAL   = cnt_t'(525);

    // Derived positions: last count of each axis and inclusive sync windows.
    localparam cnt_t H_LAST       = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST       = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_SYNC_START = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t H_SYNC_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam cnt_t V_SYNC_START = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t V_SYNC_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA 640x480@60 raster counters, syncs and blink; optional frame counter under VGA_BLINK_EN
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic             axi_aclk,
    input  logic             reset,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] DrawX,
    output logic [CNT_W-1:0] DrawY,
    output logic             hs,
    output logic             vs,
    output logic             vde,
    output logic             frame_start,
    output logic             blink
);

    cnt_t x_adv;
    cnt_t y_adv;
    logic frame_wrap;

    // Next raster position if this cycle advances; >= keeps any stray count inside the totals.
    always_comb begin
        x_adv = DrawX + 1'b1;
        y_adv = DrawY;
        if (DrawX >= H_LAST) begin
            x_adv = '0;
            if (DrawY >= V_LAST) begin
                y_adv = '0;
            end else begin
                y_adv = DrawY + 1'b1;
            end
        end
        frame_wrap = (x_adv == '0) && (y_adv == '0);
    end

    // Syncs and vde decode the next-state counts so they line up with DrawX/DrawY.
    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            hs          <= 1'b1;
            vs          <= 1'b1;
            vde         <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            DrawX       <= x_adv;
            DrawY       <= y_adv;
            hs          <= ~in_window(x_adv, H_SYNC_START, H_SYNC_END);
            vs          <= ~in_window(y_adv, V_SYNC_START, V_SYNC_END);
            vde         <= (x_adv < H_VISIBLE) && (y_adv < V_VISIBLE);
            frame_start <= frame_wrap;
        end else begin
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_BLINK_EN
    logic [FRAME_CNT_W-1:0] frame_cnt;

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (pix_ce && frame_wrap) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign blink = frame_cnt[FRAME_CNT_W-1];
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen raster timing, reset and blink
module tb_vga_timing_gen;

    logic       axi_aclk = 1'b0;
    logic       reset    = 1'b1;
    logic       pix_ce   = 1'b0;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       hs;
    logic       vs;
    logic       vde;
    logic       frame_start;
    logic       blink;

    always #5 axi_aclk = ~axi_aclk;

    vga_timing_gen dut (
        .axi_aclk    (axi_aclk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .hs          (hs),
        .vs          (vs),
        .vde         (vde),
        .frame_start (frame_start),
        .blink       (blink)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vde;
        logic       fs;
        logic       blink;
    } obs_t;

    obs_t dut_obs;
    assign dut_obs = '{x: DrawX, y: DrawY, hs: hs, vs: vs, vde: vde, fs: frame_start, blink: blink};

    obs_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model of the raster, written from the timing table.
    int   mx = 799, my = 524, mfc = 0;
    logic mhs = 1'b1, mvs = 1'b1, mvde = 1'b0, mfs = 1'b0;

    task automatic drive(input logic ce, input logic rst);
        obs_t e;
        pix_ce = ce;
        reset  = rst;
        if (rst) begin
            mx = 799; my = 524; mhs = 1'b1; mvs = 1'b1; mvde = 1'b0; mfs = 1'b0; mfc = 0;
        end else if (ce) begin
            if (mx == 799) begin
                mx = 0;
                my = (my == 524) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            mhs  = !(mx >= 656 && mx < 656 + 96);
            mvs  = !(my >= 490 && my < 492);
            mvde = (mx < 640) && (my < 480);
            mfs  = (mx == 0) && (my == 0);
            if (mfs) mfc = (mfc + 1) % 32;
        end else begin
            mfs = 1'b0;
        end
        e.x  = 10'(mx);
        e.y  = 10'(my);
        e.hs = mhs;
        e.vs = mvs;
        e.vde = mvde;
        e.fs = mfs;
`ifdef VGA_BLINK_EN
        e.blink = (mfc >= 16);
`else
        e.blink = 1'b0;
`endif
        sb.push_back(e);
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic test_reset;
        obs_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'(i % 2), 1'b1);
            e = sb.pop_front();
            n_cmp++;
            if (dut_obs !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h want %h", i, dut_obs, e);
            end
        end
    endtask

    task automatic test_first_pixel;
        obs_t e;
        drive(1'b1, 1'b0);
        e = sb.pop_front();
        n_cmp++;
        if (dut_obs !== e) begin
            n_fail++;
            $display("FAIL first_pixel: got %h want %h", dut_obs, e);
        end
        n_cmp++;
        if ({DrawX, DrawY, vde, frame_start, hs, vs} !== {10'd0, 10'd0, 4'b1111}) begin
            n_fail++;
            $display("FAIL first_pixel_fields: got x=%0d y=%0d vde=%b fs=%b hs=%b vs=%b want 0 0 1 1 1 1",
                     DrawX, DrawY, vde, frame_start, hs, vs);
        end
    endtask

    task automatic test_line;
        obs_t e;
        int hs_low = 0, hs_first = -1, vde_off = -1, fails = 0;
        for (int i = 1; i < 800 && fails < 20; i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (dut_obs !== e) begin
                n_fail++; fails++;
                $display("FAIL line x=%0d: got %h want %h", i, dut_obs, e);
            end
            if (!hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(DrawX);
            end
            if (!vde && vde_off < 0) vde_off = int'(DrawX);
        end
        n_cmp++;
        if (hs_low !== 96) begin
            n_fail++;
            $display("FAIL line_hs_width: got %0d want 96", hs_low);
        end
        n_cmp++;
        if (hs_first !== 656) begin
            n_fail++;
            $display("FAIL line_hs_start: got %0d want 656", hs_first);
        end
        n_cmp++;
        if (vde_off !== 640) begin
            n_fail++;
            $display("FAIL line_vde_off: got %0d want 640", vde_off);
        end
    endtask

    task automatic test_frame;
        obs_t e;
        int vs_low = 0, vs_x = -1, vs_y = -1, fs_cnt = 0, fails = 0;
        drive(1'b1, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 420000 && fails < 20; i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (dut_obs !== e) begin
                n_fail++; fails++;
                $display("FAIL frame cyc=%0d: got %h want %h", i, dut_obs, e);
            end
            if (!vs) begin
                if (vs_low == 0) begin
                    vs_x = int'(DrawX);
                    vs_y = int'(DrawY);
                end
                vs_low++;
            end
            if (frame_start) fs_cnt++;
        end
        n_cmp++;
        if (vs_low !== 1600) begin
            n_fail++;
            $display("FAIL frame_vs_width: got %0d want 1600", vs_low);
        end
        n_cmp++;
        if (vs_x !== 0 || vs_y !== 490) begin
            n_fail++;
            $display("FAIL frame_vs_start: got (%0d,%0d) want (0,490)", vs_x, vs_y);
        end
        n_cmp++;
        if (fs_cnt !== 1) begin
            n_fail++;
            $display("FAIL frame_fs_count: got %0d want 1", fs_cnt);
        end
    endtask

    task automatic test_alternating;
        obs_t e;
        int fs_cnt = 0, fs0 = -1, fs1 = -1, fails = 0;
        drive(1'b1, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 840002 && fails < 20; i++) begin
            drive(1'((i % 2) == 0), 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (dut_obs !== e) begin
                n_fail++; fails++;
                $display("FAIL alt cyc=%0d: got %h want %h", i, dut_obs, e);
            end
            if (frame_start) begin
                fs_cnt++;
                if (fs0 < 0) fs0 = i;
                else if (fs1 < 0) fs1 = i;
            end
        end
        n_cmp++;
        if (fs_cnt !== 2) begin
            n_fail++;
            $display("FAIL alt_fs_count: got %0d want 2", fs_cnt);
        end
        n_cmp++;
        if (fs1 - fs0 !== 840000) begin
            n_fail++;
            $display("FAIL alt_frame_period: got %0d want 840000", fs1 - fs0);
        end
    endtask

    task automatic test_midframe_reset;
        obs_t e;
        int fails = 0;
        drive(1'b1, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 300 * 800 + 701 && fails < 20; i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (dut_obs !== e) begin
                n_fail++; fails++;
                $display("FAIL mid_run cyc=%0d: got %h want %h", i, dut_obs, e);
            end
        end
        n_cmp++;
        if (DrawX !== 10'd700 || DrawY !== 10'd300 || hs !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_position: got (%0d,%0d) hs=%b want (700,300) hs=0", DrawX, DrawY, hs);
        end
        drive(1'b1, 1'b1);
        e = sb.pop_front();
        n_cmp++;
        if (dut_obs !== e) begin
            n_fail++;
            $display("FAIL mid_reset: got %h want %h", dut_obs, e);
        end
        drive(1'b1, 1'b0);
        e = sb.pop_front();
        n_cmp++;
        if (dut_obs !== e || frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_restart: got %h want %h", dut_obs, e);
        end
    endtask

    task automatic test_hold_origin;
        obs_t e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (dut_obs !== e || frame_start !== 1'b0 || DrawX !== 10'd0) begin
                n_fail++;
                $display("FAIL hold_origin[%0d]: got %h want %h", i, dut_obs, e);
            end
        end
    endtask

    task automatic test_blink;
        obs_t e;
        int fails = 0;
`ifdef VGA_BLINK_EN
        int fs_cnt = 0, rise_at = -1, fall_at = -1;
        logic prev;
        drive(1'b1, 1'b1);
        void'(sb.pop_front());
        prev = blink;
        for (int i = 0; i < 32 * 420000 && fails < 20; i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (dut_obs !== e) begin
                n_fail++; fails++;
                $display("FAIL blink cyc=%0d: got %h want %h", i, dut_obs, e);
            end
            if (frame_start) fs_cnt++;
            if (blink && !prev) rise_at = fs_cnt;
            if (!blink && prev) fall_at = fs_cnt;
            prev = blink;
        end
        n_cmp++;
        if (rise_at !== 16 || fall_at !== 32) begin
            n_fail++;
            $display("FAIL blink_edges: got rise=%0d fall=%0d want 16 32", rise_at, fall_at);
        end
`else
        drive(1'b1, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 2000 && fails < 20; i++) begin
            drive(1'(i % 3 != 0), 1'b0);
            e = sb.pop_front();
            n_cmp++;
            if (dut_obs !== e || blink !== 1'b0) begin
                n_fail++; fails++;
                $display("FAIL blink_tied cyc=%0d: got %h want %h", i, dut_obs, e);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_line();
        test_frame();
        test_alternating();
        test_midframe_reset();
        test_hold_origin();
        test_blink();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
